rv32i_icache: RTL and testbench

RV32I_ICACHE -- requirements
Module: rv32i_icache

---
 rtl/rv32i_icache_pkg.sv | 18 +
 rtl/rv32i_icache_way.sv | 61 ++++++
 rtl/rv32i_icache.sv | 241 ++++++++++++++++++++++++
 tb/tb_rv32i_icache.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_icache_pkg.sv
// Package rv32i: refill FSM state type and default cache geometry shared by the I-cache files.
`default_nettype none

package rv32i;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MISS_REQ = 2'd1,
    REFILL   = 2'd2,
    RESPOND  = 2'd3
  } icache_state_e;

  localparam int ICACHE_INDEX_BITS = 5;
  localparam int ICACHE_WORD_BITS  = 2;

endpackage

`default_nettype wire

// File: rtl/rv32i_icache_way.sv
// ============================================================================
// Module      : rv32i_icache_way
// Description : One cache way: valid bits, tag array and data array with one
//               write port and one combinational read port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rv32i_icache_way import rv32i::*; #(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int WORD_BITS  = ICACHE_WORD_BITS,
  parameter int TAG_BITS   = 32 - INDEX_BITS - WORD_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  input  logic [WORD_BITS-1:0]  i_rd_word,
  output logic                  o_rd_valid,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  output logic [31:0]           o_rd_data,
  input  logic                  i_wr_data_en,
  input  logic                  i_wr_line_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [WORD_BITS-1:0]  i_wr_word,
  input  logic [31:0]           i_wr_data,
  input  logic [TAG_BITS-1:0]   i_wr_tag
);

  localparam int SETS  = 1 << INDEX_BITS;
  localparam int WORDS = 1 << WORD_BITS;

  logic [SETS-1:0]     r_valid;
  logic [TAG_BITS-1:0] r_tag  [SETS];
  logic [31:0]         r_data [SETS*WORDS];

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_valid <= '0;
    end else if (i_wr_line_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Storage arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (i_wr_line_en) begin
      r_tag[i_wr_index] <= i_wr_tag;
    end
    if (i_wr_data_en) begin
      r_data[{i_wr_index, i_wr_word}] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[{i_rd_index, i_rd_word}];

endmodule

`default_nettype wire

// File: rtl/rv32i_icache.sv
// ============================================================================
// Module      : rv32i_icache
// Description : Blocking 1/2-way set-associative instruction cache with LRU,
//               critical-word response and deferred flush. Optional hit/miss
//               counters enabled by macro RV32I_ICACHE_STATS_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rv32i_icache import rv32i::*; #(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int WORD_BITS  = ICACHE_WORD_BITS,
  parameter int WAYS       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  input  logic        flush,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
`ifdef RV32I_ICACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);

  localparam int OFF_BITS = WORD_BITS + 2;
  localparam int TAG_BITS = 32 - INDEX_BITS - OFF_BITS;
  localparam int SETS     = 1 << INDEX_BITS;

  logic [TAG_BITS-1:0]   w_req_tag;
  logic [INDEX_BITS-1:0] w_req_idx;
  logic [WORD_BITS-1:0]  w_req_word;
  logic                  w_unused_addr;

  assign w_req_tag     = req_addr[31 -: TAG_BITS];
  assign w_req_idx     = req_addr[OFF_BITS +: INDEX_BITS];
  assign w_req_word    = req_addr[2 +: WORD_BITS];
  assign w_unused_addr = ^req_addr[1:0];

  icache_state_e         r_state;
  logic [TAG_BITS-1:0]   r_tag;
  logic [INDEX_BITS-1:0] r_idx;
  logic [WORD_BITS-1:0]  r_word;
  logic [WORD_BITS-1:0]  r_beat;
  logic [31:0]           r_crit;
  logic                  r_victim;
  logic                  r_flush_pend;
  logic                  r_resp_valid;
  logic [31:0]           r_resp_data;
  logic                  r_mem_req_valid;
  logic [31:0]           r_mem_req_addr;

  logic [WAYS-1:0]     w_way_valid;
  logic [TAG_BITS-1:0] w_way_tag  [WAYS];
  logic [31:0]         w_way_data [WAYS];
  logic [WAYS-1:0]     w_hit_vec;
  logic                w_hit;
  logic                w_hit_way;
  logic [31:0]         w_hit_data;
  logic                w_victim;
  logic                w_clear;
  logic                w_accept;
  logic                w_fill_beat;
  logic                w_last_beat;

  // A pending flush blocks acceptance so lookups never see lines about to be cleared.
  assign req_ready   = (r_state == IDLE) && !flush && !r_flush_pend;
  assign w_clear     = (r_state == IDLE) && (flush || r_flush_pend);
  assign w_accept    = req_valid && req_ready;
  assign w_fill_beat = (r_state == REFILL) && mem_rvalid;
  assign w_last_beat = w_fill_beat && (r_beat == '1);

  generate
    for (genvar g = 0; g < WAYS; g++) begin : g_way
      rv32i_icache_way #(
        .INDEX_BITS (INDEX_BITS),
        .WORD_BITS  (WORD_BITS),
        .TAG_BITS   (TAG_BITS)
      ) u_way (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (w_clear),
        .i_rd_index   (w_req_idx),
        .i_rd_word    (w_req_word),
        .o_rd_valid   (w_way_valid[g]),
        .o_rd_tag     (w_way_tag[g]),
        .o_rd_data    (w_way_data[g]),
        .i_wr_data_en (w_fill_beat && (r_victim == 1'(g))),
        .i_wr_line_en (w_last_beat && (r_victim == 1'(g))),
        .i_wr_index   (r_idx),
        .i_wr_word    (r_beat),
        .i_wr_data    (mem_rdata),
        .i_wr_tag     (r_tag)
      );
      assign w_hit_vec[g] = w_way_valid[g] && (w_way_tag[g] == w_req_tag);
    end
  endgenerate

  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = 1'b0;
    w_hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_hit_vec[w]) begin
        w_hit      = 1'b1;
        w_hit_way  = 1'(w);
        w_hit_data = w_way_data[w];
      end
    end
  end

  generate
    if (WAYS == 2) begin : g_lru
      // r_lru[set] names the least-recently-used way of that set.
      logic [SETS-1:0] r_lru;

      always_ff @(posedge clk) begin
        if (reset || w_clear) begin
          r_lru <= '0;
        end else if (w_accept && w_hit) begin
          r_lru[w_req_idx] <= ~w_hit_way;
        end else if (w_last_beat) begin
          r_lru[r_idx] <= ~r_victim;
        end
      end

      assign w_victim = !w_way_valid[0] ? 1'b0 :
                        !w_way_valid[1] ? 1'b1 : r_lru[w_req_idx];
    end else begin : g_direct
      logic w_unused_hit_way;
      assign w_unused_hit_way = w_hit_way;
      assign w_victim         = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_tag           <= '0;
      r_idx           <= '0;
      r_word          <= '0;
      r_beat          <= '0;
      r_crit          <= '0;
      r_victim        <= 1'b0;
      r_flush_pend    <= 1'b0;
      r_resp_valid    <= 1'b0;
      r_resp_data     <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (r_state != IDLE) begin
        if (flush) r_flush_pend <= 1'b1;
      end else begin
        r_flush_pend <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_hit) begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= w_hit_data;
            end else begin
              r_tag           <= w_req_tag;
              r_idx           <= w_req_idx;
              r_word          <= w_req_word;
              r_victim        <= w_victim;
              r_mem_req_valid <= 1'b1;
              r_mem_req_addr  <= {w_req_tag, w_req_idx, {OFF_BITS{1'b0}}};
              r_state         <= MISS_REQ;
            end
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_beat          <= '0;
            r_state         <= REFILL;
          end
        end
        REFILL: begin
          if (mem_rvalid) begin
            if (r_beat == r_word) r_crit <= mem_rdata;
            r_beat <= r_beat + 1'b1;
            // The requested word may be the final beat itself, so bypass it.
            if (r_beat == '1) begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= (r_word == '1) ? mem_rdata : r_crit;
              r_state      <= RESPOND;
            end
          end
        end
        RESPOND: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_data     = r_resp_data;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_mem_req_addr;

`ifdef RV32I_ICACHE_STATS_EN
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_misses;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
    end else if (w_accept) begin
      if (w_hit) begin
        if (r_stat_hits != '1) r_stat_hits <= r_stat_hits + 32'd1;
      end else begin
        if (r_stat_misses != '1) r_stat_misses <= r_stat_misses + 32'd1;
      end
    end
  end

  assign stat_hits   = r_stat_hits;
  assign stat_misses = r_stat_misses;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv32i_icache.sv
// Directed testbench for rv32i_icache at default geometry (16-byte lines, 2 ways).
`default_nettype none
`timescale 1ns/1ps

module tb_rv32i_icache;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef RV32I_ICACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rv32i_icache #(
    .INDEX_BITS (5),
    .WORD_BITS  (2),
    .WAYS       (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
`ifdef RV32I_ICACHE_STATS_EN
    ,
    .stat_hits     (stat_hits),
    .stat_misses   (stat_misses)
`endif
  );

  // Issues one request and, on a miss, plays the memory side: one stalled
  // cycle with a stray beat, then the handshake, then beats base*(k+1).
  task automatic fetch(input logic [31:0] addr, input logic [31:0] base,
                       output logic hit, output logic [31:0] data,
                       output logic [31:0] maddr);
    int n;
    req_valid = 1'b1;
    req_addr  = addr;
    n = 0;
    while (!req_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    maddr = 32'h0;
    if (resp_valid) begin
      hit  = 1'b1;
      data = resp_data;
    end else begin
      hit   = 1'b0;
      maddr = mem_req_addr;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      mem_rvalid    = 1'b0;
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
        mem_rvalid = 1'b1;
        mem_rdata  = base * 32'(k + 1);
        @(posedge clk); #1;
      end
      mem_rvalid = 1'b0;
      n = 0;
      while (!resp_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      data = resp_valid ? resp_data : 32'hDEAD_DEAD;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL reset_valids: resp_valid=%b mem_req_valid=%b, want 0/0", resp_valid, mem_req_valid);
    else n_pass++;
    n_total++;
    if (resp_data !== 32'h0 || mem_req_addr !== 32'h0)
      $display("FAIL reset_data: resp_data=%h mem_req_addr=%h, want 0/0", resp_data, mem_req_addr);
    else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: req_ready=%b, want 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_cold_miss;
    logic h; logic [31:0] d, m;
    fetch(32'h104, 32'h11, h, d, m);
    n_total++;
    if (h !== 1'b0 || m !== 32'h100)
      $display("FAIL cold_miss_req: hit=%b mem_req_addr=%h, want 0/00000100", h, m);
    else n_pass++;
    n_total++;
    if (d !== 32'h22) $display("FAIL cold_miss_data: got %h want 00000022", d);
    else n_pass++;
    fetch(32'h10C, 32'h0, h, d, m);
    n_total++;
    if (h !== 1'b1 || d !== 32'h44)
      $display("FAIL cold_hit: hit=%b data=%h, want 1/00000044", h, d);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    req_valid = 1'b1;
    req_addr  = 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp = 32'h11 * 32'(i + 1);
      n_total++;
      if (resp_valid !== 1'b1 || resp_data !== exp)
        $display("FAIL b2b_hit[%0d]: valid=%b data=%h, want 1/%h", i, resp_valid, resp_data, exp);
      else n_pass++;
      req_addr = 32'h100 + 32'(4 * (i + 1));
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lru;
    logic h; logic [31:0] d, m;
    fetch(32'h300, 32'h0300_0000, h, d, m);
    n_total++;
    if (h !== 1'b0 || m !== 32'h300 || d !== 32'h0300_0000)
      $display("FAIL lru_fill300: hit=%b addr=%h data=%h, want 0/00000300/03000000", h, m, d);
    else n_pass++;
    fetch(32'h308, 32'h0, h, d, m);
    n_total++;
    if (h !== 1'b1 || d !== 32'h0900_0000)
      $display("FAIL lru_hit300: hit=%b data=%h, want 1/09000000", h, d);
    else n_pass++;
    fetch(32'h504, 32'h0500_0000, h, d, m);
    n_total++;
    if (h !== 1'b0 || m !== 32'h500 || d !== 32'h0A00_0000)
      $display("FAIL lru_fill500: hit=%b addr=%h data=%h, want 0/00000500/0a000000", h, m, d);
    else n_pass++;
    fetch(32'h30C, 32'h0, h, d, m);
    n_total++;
    if (h !== 1'b1 || d !== 32'h0C00_0000)
      $display("FAIL lru_keep300: hit=%b data=%h, want 1/0c000000", h, d);
    else n_pass++;
    fetch(32'h104, 32'h0100_0000, h, d, m);
    n_total++;
    if (h !== 1'b0 || d !== 32'h0200_0000)
      $display("FAIL lru_evict100: hit=%b data=%h, want 0/02000000", h, d);
    else n_pass++;
  endtask

  task automatic test_flush;
    logic h; logic [31:0] d, m;
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h300;
    #1;
    n_total++;
    if (req_ready !== 1'b0) $display("FAIL flush_ready: req_ready=%b, want 0", req_ready);
    else n_pass++;
    @(posedge clk); #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    n_total++;
    if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL flush_wins: resp_valid=%b mem_req_valid=%b, want 0/0", resp_valid, mem_req_valid);
    else n_pass++;
    fetch(32'h104, 32'h0A00_0000, h, d, m);
    n_total++;
    if (h !== 1'b0 || d !== 32'h1400_0000)
      $display("FAIL flush_miss104: hit=%b data=%h, want 0/14000000", h, d);
    else n_pass++;
    fetch(32'h300, 32'h0B00_0000, h, d, m);
    n_total++;
    if (h !== 1'b0 || d !== 32'h0B00_0000)
      $display("FAIL flush_miss300: hit=%b data=%h, want 0/0b000000", h, d);
    else n_pass++;
  endtask

  task automatic test_deferred_flush;
    logic h; logic [31:0] d, m;
    int n;
    req_valid = 1'b1;
    req_addr  = 32'h708;
    @(posedge clk); #1;
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0700_0000 * 32'(k + 1);
      flush      = (k == 1);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    flush      = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    n_total++;
    if (resp_valid !== 1'b1 || resp_data !== 32'h1500_0000)
      $display("FAIL dflush_resp: valid=%b data=%h, want 1/15000000", resp_valid, resp_data);
    else n_pass++;
    @(posedge clk); #1;
    fetch(32'h708, 32'h0D00_0000, h, d, m);
    n_total++;
    if (h !== 1'b0 || d !== 32'h2700_0000)
      $display("FAIL dflush_miss: hit=%b data=%h, want 0/27000000", h, d);
    else n_pass++;
  endtask

  task automatic test_reset_mid_refill;
    logic h; logic [31:0] d, m;
    req_valid = 1'b1;
    req_addr  = 32'h904;
    @(posedge clk); #1;
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h0900_0000 * 32'(k + 1);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    reset      = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_total++;
    if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL rst_mid_outs: mem_req_valid=%b resp_valid=%b, want 0/0", mem_req_valid, resp_valid);
    else n_pass++;
    fetch(32'h904, 32'h0E00_0000, h, d, m);
    n_total++;
    if (h !== 1'b0 || m !== 32'h900 || d !== 32'h1C00_0000)
      $display("FAIL rst_mid_miss: hit=%b addr=%h data=%h, want 0/00000900/1c000000", h, m, d);
    else n_pass++;
  endtask

`ifdef RV32I_ICACHE_STATS_EN
  task automatic test_stats;
    logic h; logic [31:0] d, m;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    fetch(32'h104, 32'h11, h, d, m);
    fetch(32'h100, 32'h0, h, d, m);
    fetch(32'h108, 32'h0, h, d, m);
    fetch(32'h10C, 32'h0, h, d, m);
    n_total++;
    if (stat_hits !== 32'd3 || stat_misses !== 32'd1)
      $display("FAIL stats: hits=%0d misses=%0d, want 3/1", stat_hits, stat_misses);
    else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_addr      = 32'h0;
    flush         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = 32'h0;
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_lru();
    test_flush();
    test_deferred_flush();
    test_reset_mid_refill();
`ifdef RV32I_ICACHE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
